// File: rtl/control_fsm.sv
// Four-stage instruction sequencer (FETCH, DECODE, EXEC, WRBK) after an IDLE
// cycle; each stage strobe stays high for PHASE_CYCLES clock cycles.
module control_fsm #(
    parameter int PHASE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    output logic fetch_clk,
    output logic decode_clk,
    output logic exec_clk,
    output logic wrbk_clk
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        FETCH  = 5'b00010,
        DECODE = 5'b00100,
        EXEC   = 5'b01000,
        WRBK   = 5'b10000
    } state_t;

    // Held as a plain vector so any corrupted encoding is representable.
    logic [4:0]    state;
    logic [CW-1:0] cnt;
    state_t        succ;

    always_comb begin
        succ = FETCH;
        case (state)
            FETCH:   succ = DECODE;
            DECODE:  succ = EXEC;
            EXEC:    succ = WRBK;
            default: succ = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    cnt   <= '0;
                end
                FETCH, DECODE, EXEC, WRBK: begin
                    if (cnt == LAST) begin
                        state <= succ;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= FETCH;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Full-vector compare keeps every strobe low for a non-one-hot encoding.
    assign fetch_clk  = (state == FETCH);
    assign decode_clk = (state == DECODE);
    assign exec_clk   = (state == EXEC);
    assign wrbk_clk   = (state == WRBK);

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: one instance with PHASE_CYCLES=1 and one
// with PHASE_CYCLES=3 share clock and reset.
module tb_control_fsm;

    logic clk;
    logic rst;
    logic f1, d1, e1, w1;
    logic f3, d3, e3, w3;
    logic [3:0] o1, o3;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    control_fsm #(.PHASE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .fetch_clk(f1), .decode_clk(d1), .exec_clk(e1), .wrbk_clk(w1)
    );

    control_fsm #(.PHASE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .fetch_clk(f3), .decode_clk(d3), .exec_clk(e3), .wrbk_clk(w3)
    );

    assign o1 = {w1, e1, d1, f1};
    assign o3 = {w3, e3, d3, f3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {wrbk,exec,decode,fetch} in the k-th cycle after reset release.
    function automatic logic [3:0] exp_vec(input int kk, input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << (((kk - 1) / p) % 4);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_p1"}, 32'(o1), 32'h0);
        check({tag, "_p3"}, 32'(o3), 32'h0);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            check("seq_p1", 32'(o1), 32'(exp_vec(k, 1)));
            check("seq_p3", 32'(o3), 32'(exp_vec(k, 3)));
            check("onehot_p1", 32'($countones(o1)), 32'd1);
            check("onehot_p3", 32'($countones(o3)), 32'd1);
        end
    endtask

    // Called just after a negedge; rst edges land off the clock edges.
    task automatic apply_reset(input int hold);
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        #2 rst = 1'b0;
        #1 check_zero("rst_release");
        k = 0;
    endtask

    task automatic illegal_round(input logic [4:0] bad1, input logic [4:0] bad3);
        @(negedge clk);
        force dut1.state = bad1;
        force dut3.state = bad3;
        #1 check_zero("illegal");
        release dut1.state;
        release dut3.state;
        k = 0;
        run_cycles(14);
    endtask

    initial begin
        rst = 1'b1;
        #1 check_zero("por_t1");
        @(negedge clk);
        check_zero("por_t10");
        @(negedge clk);
        check_zero("por_t20");
        #2 rst = 1'b0;
        #1 check_zero("por_release");

        // Power-on sequence and one-hot check over 50 cycles (500 ns).
        run_cycles(50);

        // Restart, advance to the cycle where both instances sit in EXEC.
        apply_reset(1);
        run_cycles(7);
        check("exec_p1", 32'(e1), 32'd1);
        check("exec_p3", 32'(e3), 32'd1);

        // Mid-EXEC asynchronous reset, then a full sequence from FETCH.
        apply_reset(1);
        run_cycles(13);

        // Long reset with the clock running.
        apply_reset(10);
        run_cycles(12);

        // Illegal-state recovery with both corrupt encodings on each instance.
        illegal_round(5'b00000, 5'b00110);
        illegal_round(5'b00110, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
